// File: rtl/ex_if.sv
// ex_if: decode-to-execute operands/controls and the EX/MEM-facing results of ex_stage.
interface ex_if;
  logic [31:0] i_next_pc;
  logic [31:0] i_read_data_1;
  logic [31:0] i_read_data_2;
  logic [31:0] i_sign_extended_imm;
  logic [4:0]  i_rt;
  logic [4:0]  i_rd;
  logic [5:0]  i_function;
  logic        i_alu_src;
  logic [1:0]  i_alu_op;
  logic        i_reg_dst;
  logic        i_reg_write;
  logic        i_mem_read;
  logic        i_mem_write;
  logic        i_mem_to_reg;
  logic        i_branch;
  logic        i_flush;
  logic [31:0] o_alu_result;
  logic        o_zero;
  logic [31:0] o_write_data;
  logic [4:0]  o_write_register;
  logic [31:0] o_branch_target;
  logic        o_reg_write;
  logic        o_mem_read;
  logic        o_mem_write;
  logic        o_mem_to_reg;
  logic        o_branch;
  logic        o_stall;
  modport master (
    output i_next_pc, i_read_data_1, i_read_data_2, i_sign_extended_imm, i_rt, i_rd, i_function,
           i_alu_src, i_alu_op, i_reg_dst, i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg,
           i_branch, i_flush,
    input  o_alu_result, o_zero, o_write_data, o_write_register, o_branch_target, o_reg_write,
           o_mem_read, o_mem_write, o_mem_to_reg, o_branch, o_stall
  );
  modport slave (
    input  i_next_pc, i_read_data_1, i_read_data_2, i_sign_extended_imm, i_rt, i_rd, i_function,
           i_alu_src, i_alu_op, i_reg_dst, i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg,
           i_branch, i_flush,
    output o_alu_result, o_zero, o_write_data, o_write_register, o_branch_target, o_reg_write,
           o_mem_read, o_mem_write, o_mem_to_reg, o_branch, o_stall
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with ID/EX register, ALU, branch adder and iterative mul/div with HI/LO.
module ex_stage #(
  parameter int MD_CYCLES = 32
) (
  input logic clk,
  input logic reset,
  ex_if.slave bus
);
  localparam int CW = $clog2(MD_CYCLES);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] next_pc, rs, rt, imm, hi, lo, opb, sum, diff, r_res, a_abs, b_abs;
  logic [4:0] rt_f, rd_f;
  logic [5:0] funct;
  logic [1:0] alu_op;
  logic alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, branch;
  logic md_op, is_div, a_neg, b_neg, stall, last;
  logic [63:0] acc, step, mul_nx, div_nx, md_final;
  logic [32:0] msum, shifted, ddiff;
  logic [CW-1:0] cnt;
  assign md_op = alu_op == 2'b10 && funct[5:2] == 4'b0110;
  assign is_div = funct[1];
  assign a_neg = ~funct[0] & rs[31];
  assign b_neg = ~funct[0] & rt[31];
  assign a_abs = a_neg ? -rs : rs;
  assign b_abs = b_neg ? -rt : rt;
  // Multiply shifts the product right past the multiplier; divide shifts {rem,quot} left.
  assign msum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_abs} : 33'd0);
  assign mul_nx = {msum, acc[31:1]};
  assign shifted = acc[63:31];
  assign ddiff = shifted - {1'b0, b_abs};
  assign div_nx = ddiff[32] ? {shifted[31:0], acc[30:0], 1'b0} : {ddiff[31:0], acc[30:0], 1'b1};
  assign step = is_div ? div_nx : mul_nx;
  assign md_final = !is_div ? ((a_neg ^ b_neg) ? -step : step) :
                    rt == '0 ? {rs, 32'hFFFF_FFFF} :
                    {a_neg ? -step[63:32] : step[63:32], (a_neg ^ b_neg) ? -step[31:0] : step[31:0]};
  assign last = cnt == CW'(MD_CYCLES - 1);
  assign stall = md_op && state != DONE;
  always_comb begin
    state_nx = state;
    if (state == IDLE && md_op) state_nx = BUSY;
    else if (state == BUSY && last) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      {next_pc, rs, rt, imm, rt_f, rd_f, funct} <= '0;
      {alu_op, alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, branch} <= '0;
      {hi, lo, acc} <= '0;
      cnt <= '0;
    end else begin
      if (!stall) begin
        next_pc <= bus.i_next_pc;
        rs <= bus.i_read_data_1;
        rt <= bus.i_read_data_2;
        imm <= bus.i_sign_extended_imm;
        rt_f <= bus.i_rt;
        rd_f <= bus.i_rd;
        funct <= bus.i_function;
        alu_op <= bus.i_flush ? 2'b00 : bus.i_alu_op;
        alu_src <= bus.i_alu_src & ~bus.i_flush;
        reg_dst <= bus.i_reg_dst & ~bus.i_flush;
        reg_write <= bus.i_reg_write & ~bus.i_flush;
        mem_read <= bus.i_mem_read & ~bus.i_flush;
        mem_write <= bus.i_mem_write & ~bus.i_flush;
        mem_to_reg <= bus.i_mem_to_reg & ~bus.i_flush;
        branch <= bus.i_branch & ~bus.i_flush;
      end
      if (state == IDLE && md_op) begin
        acc <= {32'b0, a_abs};
        cnt <= '0;
      end else if (state == BUSY) begin
        acc <= step;
        cnt <= cnt + 1'b1;
        if (last) {hi, lo} <= md_final;
      end
    end
  end
  assign opb = alu_src ? imm : rt;
  assign sum = rs + opb;
  assign diff = rs - opb;
  always_comb begin
    r_res = '0;
    case (funct)
      6'h20, 6'h21: r_res = sum;
      6'h22, 6'h23: r_res = diff;
      6'h24: r_res = rs & opb;
      6'h25: r_res = rs | opb;
      6'h26: r_res = rs ^ opb;
      6'h27: r_res = ~(rs | opb);
      6'h2A: r_res = {31'b0, $signed(rs) < $signed(opb)};
      6'h2B: r_res = {31'b0, rs < opb};
      6'h10: r_res = hi;
      6'h12: r_res = lo;
      default: r_res = '0;
    endcase
  end
  assign bus.o_alu_result = alu_op == 2'b10 ? r_res : alu_op == 2'b01 ? diff : sum;
  assign bus.o_zero = bus.o_alu_result == '0;
  assign bus.o_write_data = rt;
  assign bus.o_write_register = reg_dst ? rd_f : rt_f;
  assign bus.o_branch_target = next_pc + {imm[29:0], 2'b00};
  assign bus.o_reg_write = reg_write & ~md_op;
  assign bus.o_mem_read = mem_read;
  assign bus.o_mem_write = mem_write;
  assign bus.o_mem_to_reg = mem_to_reg;
  assign bus.o_branch = branch;
  assign bus.o_stall = stall;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors for ex_stage ALU, branch target, mul/div, reset and flush behaviour.
module tb_ex_stage;
  logic clk = 0;
  logic reset = 0;
  int passed = 0;
  int total = 0;
  ex_if bus ();
  ex_stage #(.MD_CYCLES(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    bus.i_next_pc = '0;
    bus.i_read_data_1 = '0;
    bus.i_read_data_2 = '0;
    bus.i_sign_extended_imm = '0;
    bus.i_rt = '0;
    bus.i_rd = '0;
    bus.i_function = '0;
    bus.i_alu_src = 0;
    bus.i_alu_op = 2'b00;
    bus.i_reg_dst = 0;
    bus.i_reg_write = 0;
    bus.i_mem_read = 0;
    bus.i_mem_write = 0;
    bus.i_mem_to_reg = 0;
    bus.i_branch = 0;
    bus.i_flush = 0;
  endtask
  task automatic rop(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    clr();
    bus.i_alu_op = 2'b10;
    bus.i_function = f;
    bus.i_read_data_1 = a;
    bus.i_read_data_2 = b;
    bus.i_reg_dst = 1;
    bus.i_rd = 5'd5;
    bus.i_rt = 5'd7;
    bus.i_reg_write = 1;
  endtask
  task automatic wait_md(input logic fl, output int n);
    n = 0;
    while (bus.o_stall && n < 200) begin
      bus.i_flush = fl && n < 5;
      tick();
      n++;
    end
    bus.i_flush = 0;
  endtask
  task automatic md_run(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lo_e, input logic [31:0] hi_e,
                        input logic fl);
    int n;
    rop(f, a, b);
    tick();
    check({tag, "_stall"}, 32'(bus.o_stall), 32'd1);
    check({tag, "_regwr"}, 32'(bus.o_reg_write), 32'd0);
    rop(6'h12, 0, 0);
    wait_md(fl, n);
    check({tag, "_stall_cycles"}, 32'(n), 32'd33);
    tick();
    check({tag, "_lo"}, bus.o_alu_result, lo_e);
    check({tag, "_lo_regwr"}, 32'(bus.o_reg_write), 32'd1);
    rop(6'h10, 0, 0);
    tick();
    check({tag, "_hi"}, bus.o_alu_result, hi_e);
  endtask
  initial begin
    clr();
    bus.i_reg_write = 1;
    bus.i_mem_read = 1;
    bus.i_read_data_1 = 32'h1234;
    repeat (2) tick();
    check("rst_regwr", 32'(bus.o_reg_write), 32'd0);
    check("rst_memrd", 32'(bus.o_mem_read), 32'd0);
    check("rst_result", bus.o_alu_result, 32'd0);
    check("rst_stall", 32'(bus.o_stall), 32'd0);
    check("rst_btgt", bus.o_branch_target, 32'd0);
    reset = 1;
    rop(6'h2A, 32'hFFFF_FFFF, 32'd1);
    tick();
    check("slt", bus.o_alu_result, 32'd1);
    check("slt_wreg", 32'(bus.o_write_register), 32'd5);
    check("slt_zero", 32'(bus.o_zero), 32'd0);
    rop(6'h2B, 32'hFFFF_FFFF, 32'd1);
    tick();
    check("sltu", bus.o_alu_result, 32'd0);
    check("sltu_zero", 32'(bus.o_zero), 32'd1);
    clr();
    bus.i_alu_src = 1;
    bus.i_read_data_1 = 32'h100;
    bus.i_read_data_2 = 32'h7;
    bus.i_sign_extended_imm = 32'hFFFF_FFFC;
    bus.i_next_pc = 32'h40;
    bus.i_rt = 5'd9;
    bus.i_rd = 5'd3;
    bus.i_reg_write = 1;
    tick();
    check("addi", bus.o_alu_result, 32'hFC);
    check("btgt", bus.o_branch_target, 32'h30);
    check("addi_wreg", 32'(bus.o_write_register), 32'd9);
    clr();
    bus.i_alu_op = 2'b01;
    bus.i_read_data_1 = 32'h10;
    bus.i_read_data_2 = 32'h10;
    bus.i_branch = 1;
    tick();
    check("beq_zero", 32'(bus.o_zero), 32'd1);
    check("beq_branch", 32'(bus.o_branch), 32'd1);
    rop(6'h21, 32'hF0F0_1234, 32'h0FF0_FF00); tick(); check("addu", bus.o_alu_result, 32'h00E1_1134);
    rop(6'h22, 32'd5, 32'd7); tick(); check("sub", bus.o_alu_result, 32'hFFFF_FFFE);
    rop(6'h24, 32'hF0F0_1234, 32'h0FF0_FF00); tick(); check("and", bus.o_alu_result, 32'h00F0_1200);
    rop(6'h25, 32'hF0F0_1234, 32'h0FF0_FF00); tick(); check("or", bus.o_alu_result, 32'hFFF0_FF34);
    rop(6'h26, 32'hF0F0_1234, 32'h0FF0_FF00); tick(); check("xor", bus.o_alu_result, 32'hFF00_ED34);
    rop(6'h27, 32'hF0F0_1234, 32'h0FF0_FF00); tick(); check("nor", bus.o_alu_result, 32'h000F_00CB);
    rop(6'h3F, 32'hF0F0_1234, 32'h0FF0_FF00); tick(); check("badfn", bus.o_alu_result, 32'd0);
    md_run("mult", 6'h18, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b1);
    md_run("div", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    md_run("divu0", 6'h1B, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
    md_run("divovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    md_run("multu", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0);
    md_run("div100", 6'h1A, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0);
    rop(6'h18, 32'd7, 32'd9);
    tick();
    repeat (10) tick();
    reset = 0;
    rop(6'h12, 0, 0);
    tick();
    check("rstmd_stall", 32'(bus.o_stall), 32'd0);
    check("rstmd_regwr", 32'(bus.o_reg_write), 32'd0);
    check("rstmd_branch", 32'(bus.o_branch), 32'd0);
    reset = 1;
    tick();
    check("rstmd_lo", bus.o_alu_result, 32'd0);
    check("rstmd_stall2", 32'(bus.o_stall), 32'd0);
    rop(6'h10, 0, 0);
    tick();
    check("rstmd_hi", bus.o_alu_result, 32'd0);
    rop(6'h20, 32'd2, 32'd3);
    tick();
    check("rstmd_add", bus.o_alu_result, 32'd5);
    clr();
    bus.i_alu_src = 1;
    bus.i_read_data_1 = 32'h200;
    bus.i_sign_extended_imm = 32'h8;
    bus.i_mem_read = 1;
    bus.i_mem_to_reg = 1;
    bus.i_reg_write = 1;
    bus.i_flush = 1;
    tick();
    check("flush_memrd", 32'(bus.o_mem_read), 32'd0);
    check("flush_regwr", 32'(bus.o_reg_write), 32'd0);
    check("flush_m2r", 32'(bus.o_mem_to_reg), 32'd0);
    bus.i_flush = 0;
    tick();
    check("lw_memrd", 32'(bus.o_mem_read), 32'd1);
    check("lw_addr", bus.o_alu_result, 32'h208);
    clr();
    bus.i_alu_src = 1;
    bus.i_mem_write = 1;
    bus.i_read_data_1 = 32'h10;
    bus.i_read_data_2 = 32'hDEAD_BEEF;
    bus.i_sign_extended_imm = 32'h4;
    tick();
    check("sw_data", bus.o_write_data, 32'hDEAD_BEEF);
    check("sw_memwr", 32'(bus.o_mem_write), 32'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline; consumes every operand and control output of the decode stage.
- Holds the ID/EX pipeline register, the ALU, ALU-control decode, destination-register selection and the branch target adder.
- Adds an iterative multiply/divide unit with HI/LO registers, which stalls upstream stages while busy.
- Drives the EX/MEM boundary; its outputs are combinational from ID/EX-latched state.

Parameters:
- MD_CYCLES, 32, number of BUSY iterations for multiply/divide (one per operand bit).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-low reset
- i_next_pc  input  32  PC+4 of the decoded instruction
- i_read_data_1  input  32  rs value
- i_read_data_2  input  32  rt value
- i_sign_extended_imm  input  32  sign-extended immediate
- i_rt  input  5  rt field
- i_rd  input  5  rd field
- i_function  input  6  funct field
- i_alu_src  input  1  1 selects immediate as operand B
- i_alu_op  input  2  00 add, 01 sub, 10 R-type by funct, 11 add
- i_reg_dst  input  1  1 selects rd, 0 selects rt
- i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_branch  input  1 each  decode control
- i_flush  input  1  load a bubble into ID/EX
- o_alu_result  output  32  ALU / MFHI / MFLO result
- o_zero  output  1  alu_result == 0
- o_write_data  output  32  latched rt value (store data)
- o_write_register  output  5  selected destination
- o_branch_target  output  32  latched next_pc + (imm << 2), mod 2^32
- o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_branch  output  1 each  latched control
- o_stall  output  1  freeze IF/ID and PC

Behaviour:
- Reset (reset == 0 at an edge):
  - ID/EX cleared, so all control outputs are 0 and data outputs are 0.
  - HI = LO = 0.
  - FSM goes to IDLE; o_stall = 0.
  - Reset overrides an in-flight mult/div, which is abandoned with HI/LO untouched except for the clear.
- ID/EX load:
  - Each edge with o_stall = 0 captures all inputs.
  - i_flush = 1 (and not stalled) captures controls as 0; data fields are don't-care.
  - o_stall = 1 holds ID/EX unchanged. i_flush is ignored while stalled.
- Latency: an instruction presented in cycle N has its outputs valid in cycle N+1.
- Operand B = i_alu_src ? imm : rt.
- alu_op 10 funct decode:
  - 0x20 and 0x21 add; 0x22 and 0x23 sub.
  - 0x24 and; 0x25 or; 0x26 xor; 0x27 nor.
  - 0x2A signed slt; 0x2B unsigned sltu. Both produce 0 or 1.
  - 0x10 MFHI outputs HI; 0x12 MFLO outputs LO.
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU are mul/div operations.
  - Other funct values give result 0.
- No overflow traps; all arithmetic wraps mod 2^32.
- Mul/div FSM, states IDLE, BUSY, DONE:
  - IDLE → BUSY when ID/EX holds a mul/div op (operands rs, rt). Counter is cleared.
  - BUSY for exactly MD_CYCLES cycles, shift-add multiply or restoring divide, then → DONE. HI/LO are written on the BUSY→DONE edge.
  - DONE → IDLE unconditionally.
  - o_stall = (ID/EX holds mul/div) && state != DONE.
  - Consequence: a mul/div stalls for MD_CYCLES+1 cycles and occupies EX for MD_CYCLES+2 cycles.
  - o_reg_write is driven 0 for mul/div ops regardless of the latched bit.
  - A following MFHI/MFLO therefore always sees the updated HI/LO; no forwarding is needed.
- Mul/div result rules:
  - MULT/MULTU: {HI,LO} = 64-bit product, signed or unsigned respectively.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Divisor 0: LO = 0xFFFFFFFF, HI = dividend.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- o_write_register = reg_dst ? rd : rt, from latched fields.

Test Plan:
- alu_op=10, funct=0x2A, rs=0xFFFFFFFF, rt=1 → o_alu_result=1. Same operands with funct=0x2B → 0.
- alu_op=00, alu_src=1, rs=0x100, imm=0xFFFFFFFC, next_pc=0x40 → o_alu_result=0xFC, o_branch_target=0x30.
- MULT rs=0xFFFFFFFE, rt=3 → o_stall high for 33 cycles; then MFLO → 0xFFFFFFFA and MFHI → 0xFFFFFFFF.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=5, rt=0 → LO=0xFFFFFFFF, HI=5.
- reset=0 asserted mid-BUSY, then released → o_stall=0, HI=LO=0, all control outputs 0; next instruction executes normally.
- i_flush=1 alongside lw controls → next cycle o_mem_read=0 and o_reg_write=0. i_flush asserted during a stall → ignored, mul/div completes.
